adc_j_averager: RTL and testbench
=================================

Name: adc_j_averager

Overview:
- Acquisition stage directly upstream of the SPGD core; produces the cost sample J that the core latches into its J+ and J- registers.
- On each ADC_EN request from the SPGD FSM: waits a programmable DAC-settling interval, then accumulates 2^LOG2_N raw ADC samples.
- Converts the mean to the core's signed fixed-point format, drives it on ADC_IN and answers with ADC_DONE (4-phase level handshake).

Parameters:
- ADC_BITS, 14, width of the raw signed two's-complement ADC code.
- FP_WIDTH, 32, width of the fixed-point output word.
- INT_WIDTH, 16, integer bits of the output (FRAC = FP_WIDTH-INT_WIDTH).
- LOG2_N, 2, log2 of the number of samples averaged per request (N = 2^LOG2_N, range 0..8).
- CNT_WIDTH, 32, width of the settle counter and SETTLE_CYC.

Ports:
- ADC_CLK  in  1  sole clock; all state changes on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- CLR  in  1  synchronous clear, active high; driven from the SPGD REG_RESET.
- ADC_RAW  in  ADC_BITS  raw signed ADC sample; valid on every cycle.
- SETTLE_CYC  in  CNT_WIDTH  settling cycles before accumulation; sampled at request start.
- ADC_EN  in  1  acquisition request level from the SPGD FSM.
- ADC_IN  out  FP_WIDTH  averaged J, signed Q(INT_WIDTH).(FRAC).
- ADC_DONE  out  1  result-valid level.
- BUSY  out  1  high in SETTLE or ACCUM.

Behaviour:
- Reset (RST_N=0, async): state IDLE; ADC_IN=0; ADC_DONE=0; BUSY=0; accumulator=0; counters=0.
- CLR=1 at an edge: same values as reset, applied synchronously. CLR has priority over every other event in that cycle.
- States: IDLE, SETTLE, ACCUM, DONE.
- IDLE, ADC_EN=1 at edge: latch SETTLE_CYC into the settle counter; clear the accumulator and the sample counter.
  - Next state is SETTLE if SETTLE_CYC>0, otherwise ACCUM.
- SETTLE: the counter decrements each edge. The state lasts exactly SETTLE_CYC cycles, then moves to ACCUM. ADC_RAW is ignored.
- ACCUM: ADC_RAW is sign-extended and added into the accumulator on each of exactly N consecutive edges.
  - Accumulator width is ADC_BITS+LOG2_N signed, so it cannot overflow.
  - On the Nth edge: ADC_IN is loaded with the scaled result of (accumulator + current sample), ADC_DONE is set to 1, and the state moves to DONE in that same edge.
- Latency: if edge e0 is the first edge seeing ADC_EN=1 in IDLE, ADC_DONE rises at edge e0+SETTLE_CYC+N.
- Samples used are those present at edges e0+SETTLE_CYC+1 .. e0+SETTLE_CYC+N.
- DONE: ADC_DONE and ADC_IN hold while ADC_EN=1. When ADC_EN=0 at an edge: ADC_DONE goes to 0 and the state returns to IDLE; ADC_IN keeps its last value.
- A new request is accepted only from IDLE. ADC_EN must be seen low at least once (in DONE) before the next acquisition.
- Abort: if ADC_EN=0 at any edge in SETTLE or ACCUM, return to IDLE. ADC_IN is unchanged, ADC_DONE stays 0, and the partial accumulation is discarded.
- Scaling: result = acc * 2^SH, where SH = FRAC-(ADC_BITS-1)-LOG2_N.
  - SH≥0: arithmetic left shift.
  - SH<0: arithmetic right shift (floor toward -inf).
  - The result is sign-extended to FP_WIDTH. ADC full scale (±2^(ADC_BITS-1)) maps to ±1.0.
- SETTLE_CYC changes mid-request have no effect on the request in progress.
- BUSY = (state==SETTLE || state==ACCUM).

Decomposition:
- Shared package spgd_pkg holds:
  - the state encoding constants (IDLE=0, SETTLE=1, ACCUM=2, DONE=3);
  - the SH scale-shift expression as a constant function of FP_WIDTH, INT_WIDTH, ADC_BITS and LOG2_N.
- One natural sub-module: adc_scale, a combinational sign-extend-and-shift from accumulator width to FP_WIDTH.
- FSM, counters and accumulator stay in adc_j_averager.

Test Plan:
- Default params, SETTLE_CYC=4, ADC_RAW=1000 constant, ADC_EN raised -> ADC_DONE rises exactly 8 edges after the first ADC_EN edge; ADC_IN=8000 (0x00001F40).
- ADC_RAW=-8192 constant, SETTLE_CYC=0 -> ADC_DONE after 4 edges; ADC_IN=0xFFFF0000 (-1.0).
- Ramp ADC_RAW=0,1,2,...; SETTLE_CYC=2 -> the averaged samples are exactly 3,4,5,6; ADC_IN=(18)<<1=36.
- ADC_EN dropped on the 2nd ACCUM edge -> ADC_DONE never rises, ADC_IN keeps its prior value, state returns to IDLE; the next request produces a correct, fresh mean.
- ADC_EN held high after DONE -> no second acquisition; ADC_EN low for 1 cycle then high -> new acquisition with the same latency.
- RST_N pulsed low asynchronously mid-ACCUM, and CLR=1 in DONE -> ADC_IN=0, ADC_DONE=0, BUSY=0 immediately (async) or at the next edge (CLR).

Source files
------------

// File: rtl/spgd_pkg.sv
// Shared definitions for the SPGD acquisition path: averager state encoding and
// the fixed-point scale shift that maps the ADC accumulator onto the core's word.
package spgd_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSettle = 2'd1,
        StAccum  = 2'd2,
        StDone   = 2'd3
    } adc_state_e;

    // Left-shift amount (negative means right shift) so that ADC full scale maps to +/-1.0.
    function automatic int scale_shift(input int unsigned fp_width, input int unsigned int_width,
                                       input int unsigned adc_bits, input int unsigned log2_n);
        return (int'(fp_width) - int'(int_width)) - (int'(adc_bits) - 1) - int'(log2_n);
    endfunction

endpackage

// File: rtl/adc_scale.sv
// Combinational sign-extend and arithmetic shift from accumulator width to the
// fixed-point output width.
module adc_scale #(
    parameter int unsigned ACC_W    = 16,
    parameter int unsigned FP_WIDTH = 32,
    parameter int          SH       = 1
) (
    input  logic signed [ACC_W-1:0]    acc_i,
    output logic signed [FP_WIDTH-1:0] res_o
);

    logic signed [FP_WIDTH-1:0] ext;

    assign ext = FP_WIDTH'(acc_i);

    generate
        if (SH >= 0) begin : g_left
            assign res_o = ext <<< SH;
        end else begin : g_right
            // Arithmetic right shift floors toward -inf.
            assign res_o = ext >>> (-SH);
        end
    endgenerate

endmodule

// File: rtl/adc_j_averager.sv
// Acquisition stage for the SPGD core: settle, average 2^LOG2_N ADC samples and
// return the scaled mean over a 4-phase ADC_EN/ADC_DONE handshake.
module adc_j_averager
    import spgd_pkg::*;
#(
    parameter int unsigned ADC_BITS  = 14,
    parameter int unsigned FP_WIDTH  = 32,
    parameter int unsigned INT_WIDTH = 16,
    parameter int unsigned LOG2_N    = 2,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                        ADC_CLK,
    input  logic                        RST_N,
    input  logic                        CLR,
    input  logic signed [ADC_BITS-1:0]  ADC_RAW,
    input  logic        [CNT_WIDTH-1:0] SETTLE_CYC,
    input  logic                        ADC_EN,
    output logic        [FP_WIDTH-1:0]  ADC_IN,
    output logic                        ADC_DONE,
    output logic                        BUSY
);

    localparam int unsigned ACC_W = ADC_BITS + LOG2_N;
    localparam int unsigned N     = 1 << LOG2_N;
    localparam int unsigned SW    = LOG2_N + 1;
    localparam int          SH    = scale_shift(FP_WIDTH, INT_WIDTH, ADC_BITS, LOG2_N);

    adc_state_e                 state_q;
    logic [CNT_WIDTH-1:0]       settle_q;
    logic [SW-1:0]              samp_q;
    logic signed [ACC_W-1:0]    acc_q;
    logic [FP_WIDTH-1:0]        adc_in_q;
    logic                       done_q;

    logic signed [ACC_W-1:0]    raw_ext;
    logic signed [ACC_W-1:0]    acc_sum;
    logic signed [FP_WIDTH-1:0] scaled;

    assign raw_ext = ACC_W'(ADC_RAW);
    // The Nth sample is folded in combinationally so the result lands on the Nth edge.
    assign acc_sum = acc_q + raw_ext;

    adc_scale #(
        .ACC_W   (ACC_W),
        .FP_WIDTH(FP_WIDTH),
        .SH      (SH)
    ) u_scale (
        .acc_i(acc_sum),
        .res_o(scaled)
    );

    always_ff @(posedge ADC_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= StIdle;
            settle_q <= '0;
            samp_q   <= '0;
            acc_q    <= '0;
            adc_in_q <= '0;
            done_q   <= 1'b0;
        end else if (CLR) begin
            state_q  <= StIdle;
            settle_q <= '0;
            samp_q   <= '0;
            acc_q    <= '0;
            adc_in_q <= '0;
            done_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ADC_EN) begin
                        settle_q <= SETTLE_CYC;
                        samp_q   <= '0;
                        acc_q    <= '0;
                        state_q  <= (SETTLE_CYC == '0) ? StAccum : StSettle;
                    end
                end
                StSettle: begin
                    if (!ADC_EN) begin
                        state_q <= StIdle;
                    end else begin
                        settle_q <= settle_q - CNT_WIDTH'(1);
                        if (settle_q == CNT_WIDTH'(1)) begin
                            state_q <= StAccum;
                        end
                    end
                end
                StAccum: begin
                    if (!ADC_EN) begin
                        state_q <= StIdle;
                    end else if (samp_q == SW'(N - 1)) begin
                        adc_in_q <= scaled;
                        done_q   <= 1'b1;
                        state_q  <= StDone;
                    end else begin
                        acc_q  <= acc_sum;
                        samp_q <= samp_q + SW'(1);
                    end
                end
                StDone: begin
                    if (!ADC_EN) begin
                        done_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ADC_IN   = adc_in_q;
    assign ADC_DONE = done_q;
    assign BUSY     = (state_q == StSettle) || (state_q == StAccum);

endmodule

// File: tb/tb_adc_j_averager.sv
// Randomized self-checking bench for adc_j_averager against a per-request
// arithmetic model of latency, sample window and fixed-point scaling.
module tb_adc_j_averager;

    localparam int ADC_BITS  = 14;
    localparam int FP_WIDTH  = 32;
    localparam int INT_WIDTH = 16;
    localparam int LOG2_N    = 2;
    localparam int CNT_WIDTH = 32;
    localparam int N         = 1 << LOG2_N;
    localparam int SH        = (FP_WIDTH - INT_WIDTH) - (ADC_BITS - 1) - LOG2_N;

    logic                        ADC_CLK;
    logic                        RST_N;
    logic                        CLR;
    logic signed [ADC_BITS-1:0]  ADC_RAW;
    logic        [CNT_WIDTH-1:0] SETTLE_CYC;
    logic                        ADC_EN;
    logic        [FP_WIDTH-1:0]  ADC_IN;
    logic                        ADC_DONE;
    logic                        BUSY;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_in = '0;

    adc_j_averager #(
        .ADC_BITS (ADC_BITS),
        .FP_WIDTH (FP_WIDTH),
        .INT_WIDTH(INT_WIDTH),
        .LOG2_N   (LOG2_N),
        .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .ADC_CLK   (ADC_CLK),
        .RST_N     (RST_N),
        .CLR       (CLR),
        .ADC_RAW   (ADC_RAW),
        .SETTLE_CYC(SETTLE_CYC),
        .ADC_EN    (ADC_EN),
        .ADC_IN    (ADC_IN),
        .ADC_DONE  (ADC_DONE),
        .BUSY      (BUSY)
    );

    initial ADC_CLK = 1'b0;
    always #5 ADC_CLK = ~ADC_CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge ADC_CLK);
        #1;
    endtask

    function automatic int gen(input int mode, input int cval, input int j);
        if (mode == 0) return cval;
        if (mode == 1) return j;
        return int'($urandom_range(0, (1 << ADC_BITS) - 1)) - (1 << (ADC_BITS - 1));
    endfunction

    // Mean * 2^FRAC / 2^(ADC_BITS-1), expressed as sum scaled by 2^SH, floored.
    function automatic logic [31:0] model_scale(input longint sum);
        longint r;
        if (SH >= 0) r = sum * (longint'(1) << SH);
        else r = sum >>> (-SH);
        return r[31:0];
    endfunction

    // One request: j counts edges from the accepting edge (j=0).
    task automatic run_req(input int s, input int mode, input int cval, input int abort_j,
                           input int hold);
        longint sum = 0;
        int last;
        int v;
        SETTLE_CYC = CNT_WIDTH'(s);
        ADC_EN = 1'b1;
        last = (abort_j >= 0) ? abort_j : s + N;
        for (int j = 0; j <= last; j++) begin
            v = gen(mode, cval, j);
            ADC_RAW = ADC_BITS'(v);
            if (j >= s + 1 && j <= s + N) sum += longint'(v);
            if (j == abort_j) ADC_EN = 1'b0;
            step();
            if (j == 0) SETTLE_CYC = CNT_WIDTH'($urandom_range(0, 9));
            if (j == abort_j) begin
                check("abort_busy", 64'(BUSY), 64'(0));
                check("abort_done", 64'(ADC_DONE), 64'(0));
                check("abort_adc_in", 64'(ADC_IN), 64'(exp_in));
            end else begin
                check("busy", 64'(BUSY), 64'(j < s + N));
                check("done", 64'(ADC_DONE), 64'(j == s + N));
            end
        end
        if (abort_j >= 0) begin
            step();
            check("idle_after_abort", 64'(BUSY), 64'(0));
            return;
        end
        exp_in = model_scale(sum);
        check("adc_in", 64'(ADC_IN), 64'(exp_in));
        for (int h = 0; h < hold; h++) begin
            ADC_RAW = ADC_BITS'(gen(2, 0, 0));
            step();
            check("hold_done", 64'(ADC_DONE), 64'(1));
            check("hold_busy", 64'(BUSY), 64'(0));
            check("hold_adc_in", 64'(ADC_IN), 64'(exp_in));
        end
        ADC_EN = 1'b0;
        step();
        check("release_done", 64'(ADC_DONE), 64'(0));
        check("release_adc_in", 64'(ADC_IN), 64'(exp_in));
    endtask

    initial begin
        RST_N = 1'b0;
        CLR = 1'b0;
        ADC_RAW = '0;
        SETTLE_CYC = '0;
        ADC_EN = 1'b0;
        #22;
        check("rst_adc_in", 64'(ADC_IN), 64'(0));
        check("rst_done", 64'(ADC_DONE), 64'(0));
        check("rst_busy", 64'(BUSY), 64'(0));
        RST_N = 1'b1;
        step();

        run_req(4, 0, 1000, -1, 3);
        check("const1000", 64'(ADC_IN), 64'(32'h0000_1F40));
        run_req(0, 0, -8192, -1, 0);
        check("neg_full", 64'(ADC_IN), 64'(32'hFFFF_0000));
        run_req(2, 1, 0, -1, 1);
        check("ramp", 64'(ADC_IN), 64'(36));
        run_req(3, 2, 0, 3 + 2, 0);
        run_req(3, 2, 0, -1, 0);
        run_req(5, 2, 0, 2, 0);

        for (int k = 0; k < 25; k++) begin
            int s = int'($urandom_range(0, 6));
            int ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, s + N - 1)) : -1;
            run_req(s, 2, 0, ab, int'($urandom_range(0, 3)));
        end

        // Async reset in the middle of accumulation.
        SETTLE_CYC = 1;
        ADC_EN = 1'b1;
        ADC_RAW = 14'sd5;
        step();
        step();
        step();
        check("pre_rst_busy", 64'(BUSY), 64'(1));
        #2;
        RST_N = 1'b0;
        #1;
        exp_in = '0;
        check("arst_adc_in", 64'(ADC_IN), 64'(0));
        check("arst_done", 64'(ADC_DONE), 64'(0));
        check("arst_busy", 64'(BUSY), 64'(0));
        ADC_EN = 1'b0;
        step();
        RST_N = 1'b1;
        step();
        check("post_rst_busy", 64'(BUSY), 64'(0));

        // Synchronous clear while sitting in DONE.
        run_req(1, 0, 777, -1, 0);
        SETTLE_CYC = 0;
        ADC_EN = 1'b1;
        ADC_RAW = 14'sd300;
        for (int j = 0; j < N + 1; j++) step();
        check("pre_clr_done", 64'(ADC_DONE), 64'(1));
        check("pre_clr_adc_in", 64'(ADC_IN), 64'(model_scale(longint'(300 * N))));
        CLR = 1'b1;
        step();
        exp_in = '0;
        check("clr_adc_in", 64'(ADC_IN), 64'(0));
        check("clr_done", 64'(ADC_DONE), 64'(0));
        check("clr_busy", 64'(BUSY), 64'(0));
        CLR = 1'b0;
        ADC_EN = 1'b0;
        step();
        run_req(2, 2, 0, -1, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
